teclado_ctrl_eventos: RTL and testbench
=======================================

Name: teclado_ctrl_eventos

Overview:
Controller that sits after the PS/2 receive/filter chain and sequences the byte stream it produces. It consumes filtered scan-code bytes with their parity verdict and tracks the 0xE0 (extended) and 0xF0 (break) prefixes with an FSM. Complete key events are queued in a small FIFO and handed to one downstream consumer (display/ALU logic) over a valid/ready handshake. It also counts parity errors and flags queue overflow.

Parameters:
PROF_FIFO, 8, FIFO depth in events; must be a power of 2, minimum 2.
ANCHO_PTR, 3, pointer width; must equal log2(PROF_FIFO).
TIMEOUT_CICLOS, 1000000, prefix timeout in reloj cycles (10 ms at 100 MHz); used only with the optional feature.

Ports:
reloj  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
dato_in  input  8  filtered scan-code byte.
tick_in  input  1  one-cycle strobe: dato_in/paridad_ok valid.
paridad_ok  input  1  1 = parity check passed for this byte.
evt_code  output  8  head-of-queue key code.
evt_ext  output  1  head event had the 0xE0 prefix.
evt_break  output  1  head event is a release (had 0xF0).
evt_valid  output  1  queue not empty.
evt_ready  input  1  consumer accepts the head this cycle.
clr_ovf  input  1  one-cycle pulse: clears the overflow flag.
fifo_cnt  output  ANCHO_PTR+1  number of queued events.
overflow  output  1  sticky: an event was dropped because the queue was full.
err_cnt  output  8  parity-error count; saturates at 255.
ocupado  output  1  1 while the FSM is not in IDLE (a prefix is pending).

Behaviour:
- Reset (reset=0 at a clock edge):
  - FSM returns to IDLE.
  - FIFO is emptied (pointers = 0, fifo_cnt = 0, evt_valid = 0).
  - evt_code = 0x00, evt_ext = 0, evt_break = 0.
  - overflow = 0, err_cnt = 0, ocupado = 0.
  - Reset mid-sequence discards any pending prefix.
- FSM states: IDLE, EXT, BRK, EXT_BRK. ocupado = (state != IDLE).
- Every transition below requires tick_in=1; with tick_in=0 the state holds.
- tick_in with paridad_ok=0:
  - Byte is discarded.
  - err_cnt increments, saturating at 255.
  - FSM goes to IDLE regardless of state.
- tick_in with paridad_ok=1:
  - dato_in=0xE0: IDLE->EXT, BRK->EXT_BRK; EXT and EXT_BRK hold.
  - dato_in=0xF0: IDLE->BRK, EXT->EXT_BRK; BRK and EXT_BRK hold.
  - Any other byte: push {ext = state in EXT/EXT_BRK, break = state in BRK/EXT_BRK, code = dato_in}, then FSM goes to IDLE.
- FIFO is first-word-fall-through:
  - evt_* always reflect the head entry.
  - evt_valid = (fifo_cnt != 0).
  - A pushed event appears on evt_* with evt_valid=1 on the cycle after the tick_in edge (1-cycle latency into an empty queue).
- Pop: occurs when evt_valid & evt_ready at a clock edge. The next entry is presented on the following cycle. evt_ready while empty is ignored.
- Simultaneous push and pop:
  - Allowed at any fill level, including full.
  - Push is accepted when full only if a pop occurs in the same cycle; fifo_cnt is unchanged.
- Push while full with no pop: event dropped, overflow set to 1, FIFO contents unchanged.
- overflow clears only on reset or clr_ovf=1. If a drop and clr_ovf happen in the same cycle, set wins.
- Pointers wrap modulo PROF_FIFO. fifo_cnt ranges 0..PROF_FIFO.
- Outputs of empty slots: evt_* hold the last head value, with evt_valid=0.

Optional Feature:
- Macro TECLADO_TIMEOUT_EN.
- Defined:
  - A counter runs while ocupado=1 and restarts on every accepted tick_in.
  - If it reaches TIMEOUT_CICLOS with no byte, the FSM returns to IDLE.
  - On timeout, err_cnt increments (saturating) and no event is pushed.
  - The counter is held at 0 in IDLE and cleared on reset.
- Not defined: no counter logic; a prefix state persists until the next byte arrives.

Test Plan:
1. Bytes 0x1C (ok), evt_ready=1 -> next cycle evt_valid=1, evt_code=0x1C, evt_ext=0, evt_break=0; then popped, fifo_cnt returns to 0.
2. Bytes 0xE0, 0xF0, 0x75 (all ok), evt_ready=0 -> ocupado=1 between bytes; one event {code 0x75, ext=1, break=1}; fifo_cnt=1.
3. PROF_FIFO=8, evt_ready=0, 9 make codes 0x01..0x09 -> fifo_cnt=8, overflow=1, head=0x01; pop all -> 0x01..0x08 in order; clr_ovf -> overflow=0.
4. 0xF0 ok, then 0x1C with paridad_ok=0, then 0x1C ok -> err_cnt=1; single event {0x1C, break=0}. Also 256 bad bytes -> err_cnt=255.
5. Queue full, push and pop in the same cycle -> fifo_cnt stays 8, overflow stays 0, new code at the tail.
6. With TECLADO_TIMEOUT_EN and TIMEOUT_CICLOS=100: 0xE0 then idle 100 cycles -> ocupado falls to 0, err_cnt=1, no event; reset asserted mid-prefix -> IDLE, all outputs at reset values.

Source files
------------

// File: rtl/teclado_ctrl_eventos.sv
// -----------------------------------------------------------------------------
// teclado_ctrl_eventos
//
// Purpose:
//   Event sequencer that sits after the PS/2 receive/filter chain. It tracks
//   the 0xE0 (extended) and 0xF0 (break) prefixes with a small FSM. Each
//   complete key event goes into a first-word-fall-through FIFO, and the
//   consumer drains that FIFO over a valid/ready handshake. The block also
//   counts parity errors (saturating at 255) and keeps a sticky overflow flag
//   for events dropped on a full queue.
//
// Optional feature (macro TECLADO_TIMEOUT_EN):
//   When defined, a pending prefix is abandoned after TIMEOUT_CICLOS cycles
//   without a new byte. A timeout also counts as an error. When the macro is
//   undefined, a prefix stays pending until the next byte arrives.
//
// Ports:
//   reloj       in   system clock, rising edge
//   reset       in   synchronous reset, active low
//   dato_in     in   [7:0] filtered scan-code byte
//   tick_in     in   strobe: dato_in / paridad_ok valid this cycle
//   paridad_ok  in   parity verdict for the byte
//   evt_code    out  [7:0] head event key code
//   evt_ext     out  head event had the 0xE0 prefix
//   evt_break   out  head event is a release (had the 0xF0 prefix)
//   evt_valid   out  queue not empty
//   evt_ready   in   consumer takes the head this cycle
//   clr_ovf     in   pulse that clears the overflow flag
//   fifo_cnt    out  [ANCHO_PTR:0] number of queued events
//   overflow    out  sticky: an event was dropped on a full queue
//   err_cnt     out  [7:0] parity / timeout error count, saturating
//   ocupado     out  a prefix is pending (FSM not in IDLE)
// -----------------------------------------------------------------------------
module teclado_ctrl_eventos #(
   parameter int PROF_FIFO      = 8,
   parameter int ANCHO_PTR      = 3,
   parameter int TIMEOUT_CICLOS = 1000000
) (
   input  logic                 reloj,
   input  logic                 reset,
   input  logic [7:0]           dato_in,
   input  logic                 tick_in,
   input  logic                 paridad_ok,
   output logic [7:0]           evt_code,
   output logic                 evt_ext,
   output logic                 evt_break,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   input  logic                 clr_ovf,
   output logic [ANCHO_PTR:0]   fifo_cnt,
   output logic                 overflow,
   output logic [7:0]           err_cnt,
   output logic                 ocupado
);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} estado_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } evento_t;

   localparam logic [ANCHO_PTR:0] CNT_LLENO = (ANCHO_PTR+1)'(PROF_FIFO);

   estado_t              estado_q, estado_d;
   evento_t              mem_q [PROF_FIFO];
   evento_t              cabeza_q, cabeza_d;
   evento_t              evento_nuevo;
   logic [ANCHO_PTR-1:0] rd_q, wr_q, rd_sig;
   logic [ANCHO_PTR:0]   cnt_q, cnt_d;
   logic                 ovf_q;
   logic [7:0]           err_q;

   logic byte_ok, byte_malo, push_req, lleno, pop, push, descarte, timeout;

   assign byte_ok   = tick_in &  paridad_ok;
   assign byte_malo = tick_in & ~paridad_ok;
   assign push_req  = byte_ok & (dato_in != 8'hE0) & (dato_in != 8'hF0);

   // ---------------- prefix FSM: state register ----------------
   always_ff @(posedge reloj) begin
      if (!reset) estado_q <= IDLE;
      else        estado_q <= estado_d;
   end

   // ---------------- prefix FSM: next state ----------------
   always_comb begin
      estado_d = estado_q;
      if (byte_malo || timeout) begin
         estado_d = IDLE;
      end else if (byte_ok) begin
         unique case (dato_in)
            8'hE0: begin
               if (estado_q == IDLE)     estado_d = EXT;
               else if (estado_q == BRK) estado_d = EXT_BRK;
            end
            8'hF0: begin
               if (estado_q == IDLE)     estado_d = BRK;
               else if (estado_q == EXT) estado_d = EXT_BRK;
            end
            default: estado_d = IDLE;
         endcase
      end
   end

   // ---------------- prefix FSM: outputs ----------------
   always_comb begin
      ocupado           = (estado_q != IDLE);
      evento_nuevo.ext  = (estado_q == EXT) || (estado_q == EXT_BRK);
      evento_nuevo.brk  = (estado_q == BRK) || (estado_q == EXT_BRK);
      evento_nuevo.code = dato_in;
   end

   // ---------------- optional prefix timeout ----------------
`ifdef TECLADO_TIMEOUT_EN
   localparam int ANCHO_TMO = $clog2(TIMEOUT_CICLOS + 1);
   logic [ANCHO_TMO-1:0] tmo_q;

   // Fires on the TIMEOUT_CICLOS-th consecutive byte-less cycle in a prefix state.
   assign timeout = (estado_q != IDLE) && !tick_in &&
                    (tmo_q == ANCHO_TMO'(TIMEOUT_CICLOS - 1));

   always_ff @(posedge reloj) begin
      if (!reset)                                tmo_q <= '0;
      else if (estado_q == IDLE || tick_in || timeout) tmo_q <= '0;
      else                                       tmo_q <= tmo_q + 1'b1;
   end
`else
   assign timeout = 1'b0;
   // The timeout length only matters when the counter is built in.
   logic [31:0] unused_tmo;
   assign unused_tmo = TIMEOUT_CICLOS;
`endif

   // ---------------- FIFO control ----------------
   assign lleno    = (cnt_q == CNT_LLENO);
   assign pop      = (cnt_q != '0) & evt_ready;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign push     = push_req & (~lleno | pop);
   assign descarte = push_req & lleno & ~pop;
   assign rd_sig   = rd_q + ANCHO_PTR'(pop);
   assign cnt_d    = cnt_q + (ANCHO_PTR+1)'(push) - (ANCHO_PTR+1)'(pop);

   // The head is kept in a register so that evt_* keep the last head value
   // once the queue drains. If the slot that becomes the head is written in
   // this same cycle, take the incoming event rather than the stale RAM word.
   always_comb begin
      cabeza_d = cabeza_q;
      if (cnt_d != '0) begin
         if (push && (wr_q == rd_sig)) cabeza_d = evento_nuevo;
         else                          cabeza_d = mem_q[rd_sig];
      end
   end

   always_ff @(posedge reloj) begin
      if (push) mem_q[wr_q] <= evento_nuevo;
   end

   always_ff @(posedge reloj) begin
      if (!reset) begin
         rd_q     <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
         cabeza_q <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 8'h00;
      end else begin
         rd_q     <= rd_sig;
         wr_q     <= wr_q + ANCHO_PTR'(push);
         cnt_q    <= cnt_d;
         cabeza_q <= cabeza_d;
         // A drop in the same cycle as clr_ovf leaves the flag set.
         if (descarte)     ovf_q <= 1'b1;
         else if (clr_ovf) ovf_q <= 1'b0;
         if ((byte_malo || timeout) && (err_q != 8'hFF)) err_q <= err_q + 8'h01;
      end
   end

   assign evt_code  = cabeza_q.code;
   assign evt_ext   = cabeza_q.ext;
   assign evt_break = cabeza_q.brk;
   assign evt_valid = (cnt_q != '0);
   assign fifo_cnt  = cnt_q;
   assign overflow  = ovf_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_teclado_ctrl_eventos.sv
// -----------------------------------------------------------------------------
// tb_teclado_ctrl_eventos
//
// Purpose:
//   Self-checking bench for teclado_ctrl_eventos. A queue-based reference
//   model, built from the event rules, predicts every output after each
//   clock edge. Directed sequences come first, then randomized traffic.
//   Define TECLADO_TIMEOUT_EN to also exercise the prefix timeout, which is
//   set to 100 cycles here.
// -----------------------------------------------------------------------------
module tb_teclado_ctrl_eventos;

   localparam int PROF  = 8;
   localparam int ANCHO = 3;
   localparam int TMO   = 100;

   logic             reloj = 1'b0;
   logic             reset = 1'b0;
   logic [7:0]       dato_in = 8'h00;
   logic             tick_in = 1'b0;
   logic             paridad_ok = 1'b1;
   logic [7:0]       evt_code;
   logic             evt_ext, evt_break, evt_valid;
   logic             evt_ready = 1'b0;
   logic             clr_ovf = 1'b0;
   logic [ANCHO:0]   fifo_cnt;
   logic             overflow;
   logic [7:0]       err_cnt;
   logic             ocupado;

   teclado_ctrl_eventos #(
      .PROF_FIFO      (PROF),
      .ANCHO_PTR      (ANCHO),
      .TIMEOUT_CICLOS (TMO)
   ) dut (
      .reloj      (reloj),
      .reset      (reset),
      .dato_in    (dato_in),
      .tick_in    (tick_in),
      .paridad_ok (paridad_ok),
      .evt_code   (evt_code),
      .evt_ext    (evt_ext),
      .evt_break  (evt_break),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .clr_ovf    (clr_ovf),
      .fifo_cnt   (fifo_cnt),
      .overflow   (overflow),
      .err_cnt    (err_cnt),
      .ocupado    (ocupado)
   );

   always #5 reloj = ~reloj;

   // ---------------- reference model ----------------
   typedef struct {
      bit [7:0] code;
      bit       ext;
      bit       brk;
   } ev_t;

   ev_t cola[$];
   ev_t ult;
   bit  m_ext, m_brk, m_ovf;
   int  m_err, m_tmo;

   int errores = 0;
   int total   = 0;

   task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      total++;
      if (obs !== esp) begin
         errores++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, esp, $time);
      end
   endtask

   task automatic model_reset();
      cola.delete();
      ult   = '{8'h00, 1'b0, 1'b0};
      m_ext = 0; m_brk = 0; m_ovf = 0;
      m_err = 0; m_tmo = 0;
   endtask

   task automatic model_step(input bit t, input bit [7:0] d, input bit p,
                             input bit r, input bit c);
      bit  pop, tiene_push, ovf_set;
      int  n0;
      ev_t nv;
      n0 = cola.size();
      pop = (n0 != 0) && r;
      tiene_push = 0;
      ovf_set = 0;
      if (t) begin
         m_tmo = 0;
         if (!p) begin
            if (m_err < 255) m_err++;
            m_ext = 0; m_brk = 0;
         end else if (d == 8'hE0) begin
            m_ext = 1;
         end else if (d == 8'hF0) begin
            m_brk = 1;
         end else begin
            nv = '{d, m_ext, m_brk};
            tiene_push = 1;
            m_ext = 0; m_brk = 0;
         end
      end else if (m_ext || m_brk) begin
`ifdef TECLADO_TIMEOUT_EN
         m_tmo++;
         if (m_tmo == TMO) begin
            m_ext = 0; m_brk = 0; m_tmo = 0;
            if (m_err < 255) m_err++;
         end
`endif
      end else begin
         m_tmo = 0;
      end
      if (pop) void'(cola.pop_front());
      if (tiene_push) begin
         if (n0 < PROF || pop) cola.push_back(nv);
         else                  ovf_set = 1;
      end
      if (c)       m_ovf = 0;
      if (ovf_set) m_ovf = 1;
      if (cola.size() > 0) ult = cola[0];
   endtask

   task automatic check_all();
      comprobar("evt_valid", evt_valid, cola.size() != 0);
      comprobar("fifo_cnt",  fifo_cnt,  cola.size());
      comprobar("evt_code",  evt_code,  ult.code);
      comprobar("evt_ext",   evt_ext,   ult.ext);
      comprobar("evt_break", evt_break, ult.brk);
      comprobar("overflow",  overflow,  m_ovf);
      comprobar("err_cnt",   err_cnt,   m_err);
      comprobar("ocupado",   ocupado,   m_ext | m_brk);
   endtask

   // One clock cycle: drive at the falling edge, sample 1 time unit after the rising edge.
   task automatic ciclo(input bit t, input bit [7:0] d, input bit p,
                        input bit r, input bit c);
      @(negedge reloj);
      tick_in = t; dato_in = d; paridad_ok = p; evt_ready = r; clr_ovf = c;
      model_step(t, d, p, r, c);
      @(posedge reloj);
      #1;
      check_all();
   endtask

   task automatic aplicar_reset();
      @(negedge reloj);
      reset = 1'b0; tick_in = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
      @(posedge reloj);
      #1;
      model_reset();
      check_all();
      @(negedge reloj);
      reset = 1'b1;
   endtask

   task automatic vaciar();
      for (int i = 0; i < PROF + 1; i++) ciclo(0, 8'h00, 1, 1, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit       t, p, r, c;
      bit [7:0] d;
      int       sel;

      // Reset state
      aplicar_reset();
      comprobar("rst_code",  evt_code, 8'h00);
      comprobar("rst_valid", evt_valid, 1'b0);
      comprobar("rst_err",   err_cnt, 8'h00);

      // 1: single make code, consumer ready
      ciclo(1, 8'h1C, 1, 1, 0);
      comprobar("t1_valid", evt_valid, 1'b1);
      comprobar("t1_code",  evt_code, 8'h1C);
      ciclo(0, 8'h00, 1, 1, 0);
      comprobar("t1_cnt0", fifo_cnt, 0);

      // 2: extended break sequence
      ciclo(1, 8'hE0, 1, 0, 0);
      comprobar("t2_ocup_e0", ocupado, 1'b1);
      ciclo(1, 8'hF0, 1, 0, 0);
      comprobar("t2_ocup_f0", ocupado, 1'b1);
      ciclo(1, 8'h75, 1, 0, 0);
      comprobar("t2_code", evt_code, 8'h75);
      comprobar("t2_ext",  evt_ext, 1'b1);
      comprobar("t2_brk",  evt_break, 1'b1);
      comprobar("t2_cnt",  fifo_cnt, 1);
      vaciar();

      // 3: overflow on the ninth event, ordered drain, clear
      for (int i = 1; i <= 9; i++) ciclo(1, 8'(i), 1, 0, 0);
      comprobar("t3_cnt",  fifo_cnt, PROF);
      comprobar("t3_ovf",  overflow, 1'b1);
      comprobar("t3_head", evt_code, 8'h01);
      for (int i = 1; i <= 8; i++) begin
         comprobar("t3_order", evt_code, i);
         ciclo(0, 8'h00, 1, 1, 0);
      end
      comprobar("t3_empty", evt_valid, 1'b0);
      ciclo(0, 8'h00, 1, 0, 1);
      comprobar("t3_clr", overflow, 1'b0);

      // 4: parity error cancels a pending break, then saturation
      aplicar_reset();
      ciclo(1, 8'hF0, 1, 0, 0);
      ciclo(1, 8'h1C, 0, 0, 0);
      ciclo(1, 8'h1C, 1, 0, 0);
      comprobar("t4_err",  err_cnt, 8'd1);
      comprobar("t4_code", evt_code, 8'h1C);
      comprobar("t4_brk",  evt_break, 1'b0);
      comprobar("t4_cnt",  fifo_cnt, 1);
      vaciar();
      for (int i = 0; i < 256; i++) ciclo(1, 8'(i), 0, 0, 0);
      comprobar("t4_sat", err_cnt, 8'd255);

      // 5: simultaneous push and pop on a full queue
      aplicar_reset();
      for (int i = 1; i <= 8; i++) ciclo(1, 8'(i), 1, 0, 0);
      ciclo(1, 8'h55, 1, 1, 0);
      comprobar("t5_cnt", fifo_cnt, PROF);
      comprobar("t5_ovf", overflow, 1'b0);
      for (int i = 0; i < 7; i++) ciclo(0, 8'h00, 1, 1, 0);
      comprobar("t5_tail", evt_code, 8'h55);
      vaciar();

      // Reset while a prefix is pending
      ciclo(1, 8'hE0, 1, 0, 0);
      aplicar_reset();
      comprobar("rst_mid_ocup", ocupado, 1'b0);
      ciclo(1, 8'h2A, 1, 0, 0);
      comprobar("rst_mid_ext", evt_ext, 1'b0);
      vaciar();

`ifdef TECLADO_TIMEOUT_EN
      // 6: prefix timeout
      aplicar_reset();
      ciclo(1, 8'hE0, 1, 0, 0);
      for (int i = 0; i < TMO - 1; i++) ciclo(0, 8'h00, 1, 0, 0);
      comprobar("t6_still", ocupado, 1'b1);
      ciclo(0, 8'h00, 1, 0, 0);
      comprobar("t6_ocup", ocupado, 1'b0);
      comprobar("t6_err",  err_cnt, 8'd1);
      comprobar("t6_cnt",  fifo_cnt, 0);
      ciclo(1, 8'hE0, 1, 0, 0);
      aplicar_reset();
      comprobar("t6_rst", ocupado, 1'b0);
`endif

      // Randomized traffic: slow consumer first, then fast consumer
      aplicar_reset();
      for (int n = 0; n < 3000; n++) begin
         t   = ($urandom % 3) != 0;
         sel = $urandom % 8;
         d   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
         p   = ($urandom % 16) != 0;
         r   = (n < 1500) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
         c   = ($urandom % 32) == 0;
         ciclo(t, d, p, r, c);
      end

      $display("Result: errors=%0d of %0d checks", errores, total);
      $finish;
   end

endmodule
